// File: rtl/lzc_norm_pipe.sv
`default_nettype none
// ============================================================================
// Module   : lzc_norm_pipe
// Purpose  : Pipelined leading-zero/one counter with MSB-aligning normaliser
//            and an elastic valid/ready pipeline.
// Revision : 1.0  initial release
// ============================================================================
module lzc_norm_pipe #(
   parameter  int W      = 16,
   parameter  int STAGES = 2,
   localparam int CW     = $clog2(W + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          valid_i,
   output logic          ready_o,
   input  logic [W-1:0]  data_i,
   input  logic          lead_one_i,
   output logic          valid_o,
   input  logic          ready_i,
   output logic [CW-1:0] cnt_o,
   output logic          zero_o,
   output logic [W-1:0]  norm_o
);

   localparam int LG          = $clog2(W);
   localparam int SHIFT_STAGE = (STAGES > 1) ? 1 : 0;

   // Leading ones are counted as leading zeros of the inverted operand.
   logic [W-1:0] tree_in;
   assign tree_in = lead_one_i ? ~data_i : data_i;

   // Level n holds (W >> (n+1)) groups, each with an (n+1)-bit count and an
   // all-zero flag; the all-zero case of a group is carried by the flag alone.
   for (genvar n = 0; n < LG; n++) begin : g_lvl
      localparam int GN = W >> (n + 1);
      logic [n:0] c [GN];
      logic       z [GN];
      for (genvar i = 0; i < GN; i++) begin : g_node
         if (n == 0) begin : g_leaf
            assign c[i] = ~tree_in[W-1-2*i];
            assign z[i] = ~(tree_in[W-1-2*i] | tree_in[W-2-2*i]);
         end else begin : g_merge
            assign c[i] = g_lvl[n-1].z[2*i] ? {1'b1, g_lvl[n-1].c[2*i+1]}
                                             : {1'b0, g_lvl[n-1].c[2*i]};
            assign z[i] = g_lvl[n-1].z[2*i] & g_lvl[n-1].z[2*i+1];
         end
      end
   end

   logic          tree_zero;
   logic [CW-1:0] tree_cnt;
   assign tree_zero = g_lvl[LG-1].z[0];
   assign tree_cnt  = tree_zero ? CW'(W) : {1'b0, g_lvl[LG-1].c[0]};

   // word carries the raw operand before the shift stage and the normalised
   // mantissa from the shift stage onward.
   logic [STAGES-1:0] take;
   logic              v    [STAGES];
   logic [W-1:0]      word [STAGES];
   logic [CW-1:0]     cnt  [STAGES];
   logic              zero [STAGES];

   // A stage may load when any stage at or after it is empty, or the sink is ready.
   always_comb begin
      take = '0;
      for (int k = 0; k < STAGES; k++) begin
         take[k] = ready_i;
         for (int j = k; j < STAGES; j++) begin
            if (!v[j]) take[k] = 1'b1;
         end
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic          src_v;
      logic [W-1:0]  base;
      logic [W-1:0]  src_word;
      logic [CW-1:0] src_cnt;
      logic          src_zero;

      if (k == 0) begin : g_head
         assign src_v    = valid_i;
         assign base     = data_i;
         assign src_cnt  = tree_cnt;
         assign src_zero = tree_zero;
      end else begin : g_body
         assign src_v    = v[k-1];
         assign base     = word[k-1];
         assign src_cnt  = cnt[k-1];
         assign src_zero = zero[k-1];
      end

      if (k == SHIFT_STAGE) begin : g_shift
         assign src_word = base << src_cnt;
      end else begin : g_pass
         assign src_word = base;
      end

      // Payload only moves with a valid beat so idle outputs keep their last value.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            v[k]    <= 1'b0;
            word[k] <= '0;
            cnt[k]  <= '0;
            zero[k] <= 1'b0;
         end else if (take[k]) begin
            v[k] <= src_v;
            if (src_v) begin
               word[k] <= src_word;
               cnt[k]  <= src_cnt;
               zero[k] <= src_zero;
            end
         end
      end
   end

   assign ready_o = take[0];
   assign valid_o = v[STAGES-1];
   assign cnt_o   = cnt[STAGES-1];
   assign zero_o  = zero[STAGES-1];
   assign norm_o  = word[STAGES-1];

endmodule
`default_nettype wire
